// File: rtl/eth_sd_sector_reader.sv
// eth_sd_sector_reader: streams one SD sector of FIFO words per block write request, absorbing FIFO read latency in a 2-entry skid
// Ports: rd_clk/rd_rst_n clock and async active-low reset; enable gates new sectors; fifo_rd_* FIFO read side (data one
// cycle after fifo_rd_en); sd_wr_start/sd_wr_sec_addr/sd_wr_busy block request handshake; sd_wr_data/valid/ready/last
// sector stream; sector_cnt completed sectors; active high whenever not idle.
module eth_sd_sector_reader #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned WORDS_PER_SECTOR = 128,
  parameter int unsigned LEVEL_WIDTH      = 11,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned START_SECTOR     = 0
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   sd_wr_start,
  output logic [ADDR_WIDTH-1:0]  sd_wr_sec_addr,
  input  logic                   sd_wr_busy,
  output logic [DATA_WIDTH-1:0]  sd_wr_data,
  output logic                   sd_wr_valid,
  input  logic                   sd_wr_ready,
  output logic                   sd_wr_last,
  output logic [ADDR_WIDTH-1:0]  sector_cnt,
  output logic                   active
);
  localparam int IW = $clog2(WORDS_PER_SECTOR) + 1;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, STREAM = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [IW-1:0] issued_q, issued_d;
  logic inflight_q, inflight_last_q;
  logic [1:0] skid_cnt_q, skid_cnt_d, wi;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic last0_q, last0_d, last1_q, last1_d;
  logic pop, push, rd_last;
  assign pop = (skid_cnt_q != 2'd0) && sd_wr_ready;
  assign push = inflight_q;
  assign rd_last = issued_q == IW'(WORDS_PER_SECTOR - 1);
  // A beat leaving this cycle frees a slot in time for a read issued now, which keeps 1 word/cycle without overflow
  assign fifo_rd_en = (state_q == STREAM) && !fifo_rd_empty && (issued_q < IW'(WORDS_PER_SECTOR))
                      && (({1'b0, skid_cnt_q} + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign sd_wr_start = state_q == REQ;
  assign sd_wr_sec_addr = addr_q;
  assign sd_wr_data = data0_q;
  assign sd_wr_valid = skid_cnt_q != 2'd0;
  assign sd_wr_last = sd_wr_valid && last0_q;
  assign sector_cnt = cnt_q;
  assign active = state_q != IDLE;
  assign wi = skid_cnt_q - 2'(pop);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    issued_d = (state_q == STREAM) ? issued_q + IW'(fifo_rd_en) : '0;
    unique case (state_q)
      IDLE:    state_d = (enable && fifo_rd_water_level >= LEVEL_WIDTH'(WORDS_PER_SECTOR)) ? REQ : IDLE;
      REQ:     state_d = sd_wr_busy ? STREAM : REQ;
      STREAM:  state_d = (pop && last0_q) ? DONE : STREAM;
      default: if (!sd_wr_busy) begin
        state_d = IDLE;
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
    endcase
  end
  // Skid: entry 0 is the head; a pop shifts entry 1 down, and the returning word lands at the first free slot
  always_comb begin
    data0_d = (pop && skid_cnt_q == 2'd2) ? data1_q : data0_q;
    last0_d = (pop && skid_cnt_q == 2'd2) ? last1_q : last0_q;
    data1_d = data1_q;
    last1_d = last1_q;
    if (push && wi == 2'd0) begin
      data0_d = fifo_rd_data;
      last0_d = inflight_last_q;
    end
    if (push && wi == 2'd1) begin
      data1_d = fifo_rd_data;
      last1_d = inflight_last_q;
    end
    skid_cnt_d = skid_cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= IDLE;
      addr_q <= ADDR_WIDTH'(START_SECTOR);
      cnt_q <= '0;
      issued_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      skid_cnt_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      issued_q <= issued_d;
      inflight_q <= fifo_rd_en;
      inflight_last_q <= fifo_rd_en && rd_last;
      skid_cnt_q <= skid_cnt_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
    end
  end
endmodule

// File: tb/tb_eth_sd_sector_reader.sv
// tb_eth_sd_sector_reader: directed bench with FIFO and SD controller models around eth_sd_sector_reader
module tb_eth_sd_sector_reader;
  localparam int DW = 32, W = 128, LW = 11, AW = 32;
  logic rd_clk = 1'b0;
  logic rd_rst_n, enable, fifo_rd_en, fifo_rd_empty, sd_wr_start, sd_wr_busy, sd_wr_valid, sd_wr_ready, sd_wr_last, active;
  logic [DW-1:0] fifo_rd_data, sd_wr_data;
  logic [LW-1:0] fifo_rd_water_level;
  logic [AW-1:0] sd_wr_sec_addr, sector_cnt;
  int checks = 0, failures = 0;
  always #5 rd_clk = ~rd_clk;
  eth_sd_sector_reader #(.DATA_WIDTH(DW), .WORDS_PER_SECTOR(W), .LEVEL_WIDTH(LW), .ADDR_WIDTH(AW), .START_SECTOR(0)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level), .sd_wr_start(sd_wr_start),
    .sd_wr_sec_addr(sd_wr_sec_addr), .sd_wr_busy(sd_wr_busy), .sd_wr_data(sd_wr_data), .sd_wr_valid(sd_wr_valid),
    .sd_wr_ready(sd_wr_ready), .sd_wr_last(sd_wr_last), .sector_cnt(sector_cnt), .active(active));
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, lvl_extra = 0;
  assign fifo_rd_empty = wr_ptr == rd_ptr;
  assign fifo_rd_water_level = LW'(wr_ptr - rd_ptr + lvl_extra);
  always @(posedge rd_clk) begin
    if (!rd_rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_rd_data <= mem[rd_ptr & 1023];
      rd_ptr <= rd_ptr + 1;
    end
  end
  int drop_cnt = 0;
  initial begin
    sd_wr_busy = 1'b0;
    forever begin
      @(negedge rd_clk);
      if (!rd_rst_n) begin
        sd_wr_busy = 1'b0;
        drop_cnt = 0;
      end else if (!sd_wr_busy && sd_wr_start) sd_wr_busy = 1'b1;
      else if (sd_wr_busy && sd_wr_valid && sd_wr_ready && sd_wr_last) drop_cnt = 5;
      else if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) sd_wr_busy = 1'b0;
      end
    end
  end
  int cyc = 0, beat_n = 0, rd_n = 0, bad_rd = 0, stall_viol = 0;
  logic [DW-1:0] beat_data [0:2047];
  logic beat_last [0:2047];
  int beat_cyc [0:2047];
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge rd_clk) begin
    cyc++;
    if (sd_wr_valid && sd_wr_ready && beat_n < 2048) begin
      beat_data[beat_n] = sd_wr_data;
      beat_last[beat_n] = sd_wr_last;
      beat_cyc[beat_n] = cyc;
      beat_n++;
    end
    if (fifo_rd_en) rd_n++;
    if (fifo_rd_en && fifo_rd_empty) bad_rd++;
    if (prev_stall && (!sd_wr_valid || sd_wr_data !== prev_data || sd_wr_last !== prev_last)) stall_viol++;
    prev_stall = sd_wr_valid && !sd_wr_ready;
    prev_data = sd_wr_data;
    prev_last = sd_wr_last;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask
  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr & 1023] = DW'(base + i);
      wr_ptr++;
    end
  endtask
  task automatic wait_sectors(input int target, output bit to);
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (sector_cnt == AW'(target)) begin
        to = 1'b0;
        break;
      end
      tick(1);
    end
  endtask
  task automatic count_errs(input int b0, input int n, input int base, output int errs);
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (beat_data[b0 + i] !== DW'(base + i)) errs++;
      if (beat_last[b0 + i] !== ((i % W) == W - 1)) errs++;
    end
  endtask
  task automatic test_reset;
    checks++;
    if ({sd_wr_start, sd_wr_valid, sd_wr_last, fifo_rd_en, active} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {sd_wr_start, sd_wr_valid, sd_wr_last, fifo_rd_en, active});
    end
    checks++;
    if (sd_wr_sec_addr !== 0) begin failures++; $display("FAIL reset_addr got=%0d want=0", sd_wr_sec_addr); end
    checks++;
    if (sector_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", sector_cnt); end
    checks++;
    if (sd_wr_data !== 0) begin failures++; $display("FAIL reset_data got=%0h want=0", sd_wr_data); end
    rd_rst_n = 1'b1;
    tick(1);
  endtask
  task automatic test_threshold;
    enable = 1'b1;
    sd_wr_ready = 1'b1;
    load(0, 127);
    tick(5);
    checks++;
    if ({active, sd_wr_start} !== 2'b00) begin failures++; $display("FAIL level127_idle got=%b want=00", {active, sd_wr_start}); end
    load(127, 1);
    tick(1);
    checks++;
    if (sd_wr_start !== 1'b1) begin failures++; $display("FAIL level128_start got=%b want=1", sd_wr_start); end
    checks++;
    if (sd_wr_sec_addr !== 0) begin failures++; $display("FAIL level128_addr got=%0d want=0", sd_wr_sec_addr); end
  endtask
  task automatic test_stream;
    int b0 = beat_n, r0 = rd_n, errs;
    bit to;
    wait_sectors(1, to);
    checks++;
    if (to) begin failures++; $display("FAIL stream_timeout got=timeout want=sector_cnt 1"); end
    checks++;
    if (beat_n - b0 != W) begin failures++; $display("FAIL stream_beats got=%0d want=%0d", beat_n - b0, W); end
    count_errs(b0, W, 0, errs);
    checks++;
    if (errs != 0) begin failures++; $display("FAIL stream_data got=%0d errors want=0", errs); end
    checks++;
    if (beat_cyc[b0 + W - 1] - beat_cyc[b0] != W - 1) begin
      failures++;
      $display("FAIL stream_span got=%0d want=%0d", beat_cyc[b0 + W - 1] - beat_cyc[b0], W - 1);
    end
    checks++;
    if (rd_n - r0 != W) begin failures++; $display("FAIL stream_reads got=%0d want=%0d", rd_n - r0, W); end
    checks++;
    if (sd_wr_sec_addr !== 1) begin failures++; $display("FAIL stream_next_addr got=%0d want=1", sd_wr_sec_addr); end
  endtask
  task automatic test_random_ready;
    int b0 = beat_n, r0 = rd_n, errs;
    bit to = 1'b1;
    load(1000, W);
    for (int i = 0; i < 4000; i++) begin
      sd_wr_ready = 1'($urandom_range(0, 1));
      tick(1);
      if (sector_cnt == 2) begin
        to = 1'b0;
        break;
      end
    end
    sd_wr_ready = 1'b1;
    checks++;
    if (to) begin failures++; $display("FAIL rand_timeout got=timeout want=sector_cnt 2"); end
    checks++;
    if (beat_n - b0 != W) begin failures++; $display("FAIL rand_beats got=%0d want=%0d", beat_n - b0, W); end
    count_errs(b0, W, 1000, errs);
    checks++;
    if (errs != 0) begin failures++; $display("FAIL rand_data got=%0d errors want=0", errs); end
    checks++;
    if (stall_viol != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d violations want=0", stall_viol); end
    checks++;
    if (bad_rd != 0) begin failures++; $display("FAIL rand_read_empty got=%0d want=0", bad_rd); end
    checks++;
    if (rd_n - r0 != W) begin failures++; $display("FAIL rand_reads got=%0d want=%0d", rd_n - r0, W); end
  endtask
  task automatic test_back_to_back;
    int b0, errs, k = 0;
    int addrs [0:3];
    logic ps = 1'b0;
    bit to = 1'b1;
    rd_rst_n = 1'b0;
    tick(3);
    rd_rst_n = 1'b1;
    tick(1);
    b0 = beat_n;
    load(2000, 3 * W);
    for (int i = 0; i < 6000; i++) begin
      if (sd_wr_start && !ps && k < 4) begin
        addrs[k] = int'(sd_wr_sec_addr);
        k++;
      end
      ps = sd_wr_start;
      if (sector_cnt == 3) begin
        to = 1'b0;
        break;
      end
      tick(1);
    end
    checks++;
    if (to) begin failures++; $display("FAIL b2b_timeout got=timeout want=sector_cnt 3"); end
    checks++;
    if (k != 3) begin failures++; $display("FAIL b2b_requests got=%0d want=3", k); end
    else begin
      checks++;
      if (addrs[0] != 0 || addrs[1] != 1 || addrs[2] != 2) begin
        failures++;
        $display("FAIL b2b_addrs got=%0d,%0d,%0d want=0,1,2", addrs[0], addrs[1], addrs[2]);
      end
    end
    count_errs(b0, 3 * W, 2000, errs);
    checks++;
    if (beat_n - b0 != 3 * W || errs != 0) begin
      failures++;
      $display("FAIL b2b_data got=%0d beats %0d errors want=%0d beats 0 errors", beat_n - b0, errs, 3 * W);
    end
    checks++;
    if (sector_cnt !== 3 || sd_wr_sec_addr !== 3) begin
      failures++;
      $display("FAIL b2b_counters got=cnt %0d addr %0d want=cnt 3 addr 3", sector_cnt, sd_wr_sec_addr);
    end
  endtask
  task automatic test_fifo_gap;
    int b0 = beat_n, errs;
    bit to;
    lvl_extra = W - 61;
    load(3000, 61);
    for (int i = 0; i < 500 && beat_n - b0 < 61; i++) tick(1);
    tick(20);
    checks++;
    if (sd_wr_valid !== 1'b0 || beat_n - b0 != 61) begin
      failures++;
      $display("FAIL gap_stall got=valid %b beats %0d want=valid 0 beats 61", sd_wr_valid, beat_n - b0);
    end
    lvl_extra = 0;
    load(3061, W - 61);
    wait_sectors(4, to);
    checks++;
    if (to || beat_n - b0 != W) begin failures++; $display("FAIL gap_beats got=%0d timeout=%0d want=%0d", beat_n - b0, to, W); end
    count_errs(b0, W, 3000, errs);
    checks++;
    if (errs != 0) begin failures++; $display("FAIL gap_data got=%0d errors want=0", errs); end
    checks++;
    if (beat_cyc[b0 + 61] - beat_cyc[b0 + 60] < 20) begin
      failures++;
      $display("FAIL gap_resume got=%0d cycles want>=20", beat_cyc[b0 + 61] - beat_cyc[b0 + 60]);
    end
    checks++;
    if (bad_rd != 0) begin failures++; $display("FAIL gap_read_empty got=%0d want=0", bad_rd); end
  endtask
  task automatic test_reset_mid;
    int b0 = beat_n, b1, errs, a0 = -1;
    logic ps = 1'b0;
    bit to;
    load(4000, W);
    for (int i = 0; i < 500 && beat_n - b0 < 40; i++) tick(1);
    rd_rst_n = 1'b0;
    #1;
    checks++;
    if ({sd_wr_start, sd_wr_valid, sd_wr_last, fifo_rd_en, active} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_ctrl got=%b want=00000", {sd_wr_start, sd_wr_valid, sd_wr_last, fifo_rd_en, active});
    end
    checks++;
    if (sd_wr_sec_addr !== 0 || sector_cnt !== 0) begin
      failures++;
      $display("FAIL midrst_counters got=addr %0d cnt %0d want=0 0", sd_wr_sec_addr, sector_cnt);
    end
    tick(3);
    rd_rst_n = 1'b1;
    tick(1);
    b1 = beat_n;
    load(5000, W);
    for (int i = 0; i < 4000 && sector_cnt != 1; i++) begin
      if (sd_wr_start && !ps && a0 < 0) a0 = int'(sd_wr_sec_addr);
      ps = sd_wr_start;
      tick(1);
    end
    wait_sectors(1, to);
    checks++;
    if (a0 != 0) begin failures++; $display("FAIL midrst_restart_addr got=%0d want=0", a0); end
    count_errs(b1, W, 5000, errs);
    checks++;
    if (to || beat_n - b1 != W || errs != 0) begin
      failures++;
      $display("FAIL midrst_sector got=%0d beats %0d errors want=%0d beats 0 errors", beat_n - b1, errs, W);
    end
  endtask
  initial begin
    rd_rst_n = 1'b0;
    enable = 1'b0;
    sd_wr_ready = 1'b0;
    tick(3);
    test_reset;
    test_threshold;
    test_stream;
    test_random_ready;
    test_back_to_back;
    test_fifo_gap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
